// File: rtl/dispatch_buffer.sv
// Circular dispatch buffer between decode (up to 4 entries/cycle) and the issue queue.
// Optional same-cycle decode-to-issue bypass when empty: define DISPATCH_BYPASS_EN.

package dispatch_buffer_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  fu_type;
        logic [5:0]  rob_idx;
    } issue_queue_element_t;

endpackage

module dispatch_buffer
    import dispatch_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  issue_queue_element_t [3:0]          dec_data,
    input  logic [2:0]                          dec_number,
    output logic                                dec_ready,
    input  logic [4:0]                          iq_size_left,
    output issue_queue_element_t [3:0]          iq_in_data,
    output logic [2:0]                          iq_in_data_number,
    output logic [$clog2(DEPTH):0]              buf_count
);

    localparam int unsigned LANES = 4;
    localparam int unsigned PW    = $clog2(DEPTH);
    localparam int unsigned CW    = PW + 1;

    logic [PW-1:0]        head_q;
    logic [PW-1:0]        tail_q;
    logic [CW-1:0]        count_q;
    issue_queue_element_t mem_q [DEPTH];

    logic [2:0] dec_num;
    logic [2:0] buf_avail;
    logic [2:0] iq_avail;
    logic [2:0] out_num;
    logic [2:0] buf_pop;
    logic [2:0] push_num;
    logic [2:0] push_base;
`ifdef DISPATCH_BYPASS_EN
    logic       from_dec;
`endif

    logic                 wr_en   [LANES];
    logic [PW-1:0]        wr_idx  [LANES];
    issue_queue_element_t wr_data [LANES];

    function automatic logic [2:0] min3(input logic [2:0] a, input logic [2:0] b);
        return (a < b) ? a : b;
    endfunction

    // Each source saturates at the 4-lane width of the interfaces.
    assign dec_num   = (dec_number > 3'd4)        ? 3'd4 : dec_number;
    assign buf_avail = (count_q >= CW'(LANES))    ? 3'd4 : 3'(count_q);
    assign iq_avail  = (iq_size_left >= 5'd4)     ? 3'd4 : 3'(iq_size_left);

    // Room for a full decode group, derived from registered occupancy only.
    assign dec_ready = (count_q <= CW'(DEPTH - LANES));
    assign buf_count = count_q;

    // Transfer counts for this cycle: lanes issued, lanes popped from storage, lanes stored.
    always_comb begin
        out_num   = 3'd0;
        buf_pop   = 3'd0;
        push_num  = 3'd0;
        push_base = 3'd0;
`ifdef DISPATCH_BYPASS_EN
        from_dec  = 1'b0;
`endif
        if (rst && !flush) begin
`ifdef DISPATCH_BYPASS_EN
            if (count_q == '0) begin
                // Empty: issue straight from decode, store whatever the issue queue cannot take.
                from_dec  = 1'b1;
                out_num   = min3(dec_num, iq_avail);
                push_num  = dec_num - out_num;
                push_base = out_num;
            end else begin
                out_num  = min3(buf_avail, iq_avail);
                buf_pop  = out_num;
                push_num = dec_ready ? dec_num : 3'd0;
            end
`else
            out_num  = min3(buf_avail, iq_avail);
            buf_pop  = out_num;
            push_num = dec_ready ? dec_num : 3'd0;
`endif
        end
    end

    // Issue lanes: oldest first, unused lanes forced to zero.
    always_comb begin
        for (int i = 0; i < int'(LANES); i++) begin
            iq_in_data[i] = '0;
            if (3'(i) < out_num) begin
`ifdef DISPATCH_BYPASS_EN
                if (from_dec) begin
                    iq_in_data[i] = dec_data[i];
                end else begin
                    iq_in_data[i] = mem_q[head_q + PW'(i)];
                end
`else
                iq_in_data[i] = mem_q[head_q + PW'(i)];
`endif
            end
        end
    end

    assign iq_in_data_number = out_num;

    // Write ports: stored lanes start at push_base within the decode group.
    always_comb begin
        for (int i = 0; i < int'(LANES); i++) begin
            wr_en[i]   = (3'(i) < push_num);
            wr_idx[i]  = tail_q + PW'(i);
            wr_data[i] = dec_data[2'(push_base + 3'(i))];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(LANES); i++) begin
            if (wr_en[i]) begin
                mem_q[wr_idx[i]] <= wr_data[i];
            end
        end
    end

    // Pointers and occupancy; occupancy never exceeds DEPTH so CW bits suffice.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + PW'(buf_pop);
            tail_q  <= tail_q + PW'(push_num);
            count_q <= count_q + CW'(push_num) - CW'(buf_pop);
        end
    end

endmodule

// File: tb/tb_dispatch_buffer.sv
// Randomized scoreboard bench for dispatch_buffer against a queue-based reference model.

module tb_dispatch_buffer;
    import dispatch_buffer_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned EW    = $bits(issue_queue_element_t);

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       flush;
    issue_queue_element_t [3:0] dec_data;
    logic [2:0]                 dec_number;
    logic                       dec_ready;
    logic [4:0]                 iq_size_left;
    issue_queue_element_t [3:0] iq_in_data;
    logic [2:0]                 iq_in_data_number;
    logic [$clog2(DEPTH):0]     buf_count;

    dispatch_buffer #(.DEPTH(DEPTH)) dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .dec_data          (dec_data),
        .dec_number        (dec_number),
        .dec_ready         (dec_ready),
        .iq_size_left      (iq_size_left),
        .iq_in_data        (iq_in_data),
        .iq_in_data_number (iq_in_data_number),
        .buf_count         (buf_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                   num;
        int                   ready;
        int                   count;
        issue_queue_element_t lanes [4];
    } exp_t;

    exp_t                 exp_q [$];
    issue_queue_element_t mdl   [$];
    int checks = 0;
    int errors = 0;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic issue_queue_element_t rand_elem();
        logic [95:0] tmp;
        tmp = {$urandom(), $urandom(), $urandom()};
        return issue_queue_element_t'(tmp[EW-1:0]);
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic chk_elem(input string name, input int lane,
                            input issue_queue_element_t act, input issue_queue_element_t req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s lane%0d actual=%h required=%h at %0t", name, lane, act, req, $time);
        end
    endtask

    // Drive one cycle of stimulus and record what the outputs must show during it.
    task automatic cycle(input bit r, input bit f, input int dn, input int left);
        exp_t e;
        int   sz;
        int   dnc;
        int   n;
        bit   byp;
        @(posedge clk);
        #1;
        rst          = r;
        flush        = f;
        dec_number   = 3'(dn);
        iq_size_left = 5'(left);
        for (int i = 0; i < 4; i++) dec_data[i] = rand_elem();

        for (int i = 0; i < 4; i++) e.lanes[i] = '0;
        sz  = mdl.size();
        dnc = (dn > 4) ? 4 : dn;
        byp = 1'b0;
        if (!r) begin
            mdl.delete();
            e.num   = 0;
            e.ready = 1;
            e.count = 0;
        end else begin
            e.count = sz;
            e.ready = ((int'(DEPTH) - sz) >= 4) ? 1 : 0;
`ifdef DISPATCH_BYPASS_EN
            byp = (sz == 0) && !f;
`endif
            if (byp) begin
                n = imin(imin(dnc, left), 4);
                for (int i = 0; i < n; i++) e.lanes[i] = dec_data[i];
                for (int i = n; i < dnc; i++) mdl.push_back(dec_data[i]);
                e.num = n;
            end else begin
                n = f ? 0 : imin(imin(sz, left), 4);
                for (int i = 0; i < n; i++) e.lanes[i] = mdl[i];
                e.num = n;
                if (f) begin
                    mdl.delete();
                end else begin
                    repeat (n) void'(mdl.pop_front());
                    if (e.ready == 1) begin
                        for (int i = 0; i < dnc; i++) mdl.push_back(dec_data[i]);
                    end
                end
            end
        end
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are valid every cycle; compare mid-cycle against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("iq_in_data_number", int'(iq_in_data_number), e.num);
            chk("dec_ready", int'(dec_ready), e.ready);
            chk("buf_count", int'(buf_count), e.count);
            for (int i = 0; i < 4; i++) chk_elem("iq_in_data", i, iq_in_data[i], e.lanes[i]);
        end
    end

    initial begin
        rst          = 1'b0;
        flush        = 1'b0;
        dec_number   = 3'd0;
        iq_size_left = 5'd0;
        dec_data     = '0;

        repeat (3) cycle(0, 0, 0, 0);

        // First transaction after reset
        cycle(1, 0, 3, 16);
        cycle(1, 0, 0, 16);
        cycle(1, 0, 0, 16);

        // Fill to full with the issue queue stalled; extra decode group is ignored
        cycle(1, 0, 4, 0);
        cycle(1, 0, 4, 0);
        cycle(1, 0, 2, 0);
        cycle(1, 0, 0, 0);

        // Drain two per cycle in order
        repeat (4) cycle(1, 0, 0, 2);
        cycle(1, 0, 0, 2);

        // Flush with five buffered entries and a decode group present
        cycle(1, 0, 4, 0);
        cycle(1, 0, 1, 0);
        cycle(1, 1, 4, 0);
        cycle(1, 0, 0, 4);

        // Move head near the end of storage, then push and pop across the wrap
        cycle(1, 0, 4, 0);
        cycle(1, 0, 2, 0);
        cycle(1, 0, 0, 4);
        cycle(1, 0, 4, 2);
        cycle(1, 0, 2, 0);
        cycle(1, 0, 4, 3);
        cycle(1, 0, 4, 3);
        repeat (4) cycle(1, 0, 0, 16);

        // Asynchronous reset with three entries buffered
        cycle(1, 0, 3, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 2, 4);
        #1;
        chk("async_rst_number", int'(iq_in_data_number), 0);
        chk("async_rst_ready", int'(dec_ready), 1);
        chk("async_rst_count", int'(buf_count), 0);
        for (int i = 0; i < 4; i++) chk_elem("async_rst_data", i, iq_in_data[i], '0);
        cycle(1, 0, 2, 4);
        cycle(1, 0, 0, 4);

        // Randomized traffic
        for (int k = 0; k < 2000; k++) begin
            cycle(($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1,
                  ($urandom_range(0, 99) < 4) ? 1'b1 : 1'b0,
                  int'($urandom_range(0, 4)),
                  int'($urandom_range(0, 16)));
        end

        cycle(1, 0, 0, 16);
        repeat (2) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
